// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : operation codes, FSM states and defaults for the execute-stage ALU
// rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int ALU_DATA_WIDTH = 32;
   localparam int ALU_OP_WIDTH   = 4;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_OR  = 4'b0011,
      OP_XOR = 4'b0100,
      OP_SLL = 4'b0101,
      OP_SRL = 4'b0110,
      OP_SRA = 4'b0111,
      OP_EQ  = 4'b1000,
      OP_SLT = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// ============================================================================
// alu_shift_unit : iterative 1-bit/cycle shifter, or barrel shifter when
// ALU_FAST_SHIFT_EN is defined.                                       rev 1.0
// ============================================================================
`default_nettype none

module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   flush,
   input  logic [3:0]             op,
   input  logic [DATA_WIDTH-1:0]  a,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   output logic [DATA_WIDTH-1:0]  result,
   output logic                   done
);

`ifdef ALU_FAST_SHIFT_EN

   always_comb begin
      result = a;
      case (op)
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $signed(a) >>> shamt;
         default: result = a;
      endcase
   end

   assign done = 1'b0;

`else

   logic [DATA_WIDTH-1:0]  value;
   logic [SHAMT_WIDTH-1:0] count;
   logic [3:0]             kind;
   logic [DATA_WIDTH-1:0]  step;

   always_comb begin
      step = value;
      case (kind)
         OP_SLL:  step = value << 1;
         OP_SRL:  step = value >> 1;
         default: step = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
         count <= '0;
         kind  <= 4'd0;
      end else if (flush) begin
         count <= '0;
      end else if (start) begin
         value <= a;
         count <= shamt;
         kind  <= op;
      end else if (count != '0) begin
         value <= step;
         count <= count - SHAMT_WIDTH'(1);
      end
   end

   // The final shift step is taken by the consumer capturing `result` on the
   // same edge that the count would hit zero.
   assign result = step;
   assign done   = (count == SHAMT_WIDTH'(1));

`endif

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// alu_exec_unit : execute-stage ALU with valid/ready handshake and registered
// result. Optional macro: ALU_FAST_SHIFT_EN (single-cycle shifts).    rev 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DATA_WIDTH,
   parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_WIDTH-1:0]   op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  flush_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o,
   output logic                  busy_o
);

   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

   alu_state_e             state;
   logic [3:0]             op;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   accept;
   logic                   goes_iter;
   logic                   sh_start;
   logic [DATA_WIDTH-1:0]  sh_result;
   logic                   sh_done;
   logic [DATA_WIDTH-1:0]  quick_result;

   assign op     = op_i[3:0];
   assign shamt  = b_i[SHAMT_WIDTH-1:0];
   assign in_ready = !flush_i && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
   assign accept = in_valid && in_ready;
   assign busy_o = (state != ST_IDLE);

`ifdef ALU_FAST_SHIFT_EN
   assign goes_iter = 1'b0;
`else
   assign goes_iter = is_shift_op(op) && (shamt != '0);
`endif

   assign sh_start = accept && goes_iter;

   alu_shift_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (sh_start),
      .flush  (flush_i),
      .op     (op),
      .a      (a_i),
      .shamt  (shamt),
      .result (sh_result),
      .done   (sh_done)
   );

   // Everything that completes in the accept cycle; iterative shifts only land
   // here with a zero shift amount, where the result is operand A unchanged.
   always_comb begin
      quick_result = '0;
      case (op)
         OP_ADD: quick_result = a_i + b_i;
         OP_SUB: quick_result = a_i - b_i;
         OP_AND: quick_result = a_i & b_i;
         OP_OR:  quick_result = a_i | b_i;
         OP_XOR: quick_result = a_i ^ b_i;
         OP_SLL, OP_SRL, OP_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
            quick_result = sh_result;
`else
            quick_result = a_i;
`endif
         end
         OP_EQ:   quick_result = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
         OP_SLT:  quick_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: quick_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result_o  <= '0;
         zero_o    <= 1'b1;
      end else if (flush_i) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
      end else if (accept) begin
         if (goes_iter) begin
            state     <= ST_SHIFT;
            out_valid <= 1'b0;
         end else begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result_o  <= quick_result;
            zero_o    <= (quick_result == '0);
         end
      end else begin
         case (state)
            ST_SHIFT: begin
               if (sh_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result_o  <= sh_result;
                  zero_o    <= (sh_result == '0);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// tb_alu_exec_unit : randomized self-checking bench for alu_exec_unit  rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [3:0]   op_i      = 4'd0;
   logic [W-1:0] a_i       = '0;
   logic [W-1:0] b_i       = '0;
   logic         flush_i   = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic         busy_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .flush_i   (flush_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result_o  (result_o),
      .zero_o    (zero_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      int sh;
      logic [W-1:0] all_ones;
      sh = int'(b[4:0]);
      all_ones = '1;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << sh;
         4'd6: return a >> sh;
         4'd7: return (a >> sh) | (a[W-1] ? ~(all_ones >> sh) : '0);
         4'd8: return (a == b) ? 1 : 0;
         4'd9: return (int'(a) < int'(b)) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      if (op >= 4'd5 && op <= 4'd7) return 1 + int'(b[4:0]);
      return 1;
`endif
   endfunction

   // Issue one op (releasing any held result in the same cycle), wait for the
   // result, check it, then hold it under back-pressure for `hold` cycles.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
      logic [W-1:0] exp;
      int lat;
      int elat;
      exp  = ref_alu(op, a, b);
      elat = ref_lat(op, b);
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("accept_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
      #1 lat = 1;
      while (!out_valid && lat < 100) begin
         chk("wait_ready", in_ready, 0);
         chk("wait_busy", busy_o, 1);
         @(negedge clk);
         #1 lat++;
      end
      chk("latency", lat, elat);
      chk("result", result_o, exp);
      chk("zero", zero_o, (exp == 0) ? 1 : 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_result", result_o, exp);
         chk("hold_ready", in_ready, 0);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk("drain_busy", busy_o, 0);
      chk("drain_valid", out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] prev_exp;
      bit           seen;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result_o, 0);
      chk("rst_zero", zero_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(4'd1, 32'd5, 32'd7, 0);
      chk("t1_const", result_o, 32'hFFFF_FFFE);
      do_op(4'd7, 32'h8000_0000, 32'd4, 1);
      chk("t2_const", result_o, 32'hF800_0000);
      do_op(4'd5, 32'h1234, 32'd0, 0);
      do_op(4'd8, 32'd9, 32'd9, 0);
      do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(4'd0, 32'd3, 32'd4, 3);
      do_op(4'd12, 32'hDEAD_BEEF, 32'h1, 0);
      do_op(4'd3, 32'h55, 32'd0, 0);

`ifndef ALU_FAST_SHIFT_EN
      // reset while shifting; the pending 0x55 must be wiped
      @(negedge clk);
      op_i = 4'd7; a_i = 32'h8000_0000; b_i = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_result", result_o, 0);
      chk("mid_rst_zero", zero_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_ready", in_ready, 1);

      // flush in cycle N+3 of a long shift, racing a new in_valid
      do_op(4'd4, 32'h0F0F, 32'hF0F0, 0);
      @(negedge clk);
      op_i = 4'd6; a_i = 32'hFFFF_0000; b_i = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      flush_i = 1'b1; in_valid = 1'b1; op_i = 4'd0;
      #1 chk("flush_ready", in_ready, 0);
      @(negedge clk);
      flush_i = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_busy", busy_o, 0);
      chk("flush_valid", out_valid, 0);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", seen, 0);
`endif

      // back-to-back single-cycle ops at full rate
      drain();
      prev_exp = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k > 0) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", result_o, prev_exp);
         end
         op = 4'($urandom_range(0, 15));
         if (op >= 4'd5 && op <= 4'd7) op = 4'd1;
         a = $urandom;
         b = (k == 3) ? a : $urandom;
         op_i = op; a_i = a; b_i = b; in_valid = 1'b1; out_ready = 1'b1;
         #1 chk("b2b_ready", in_ready, 1);
         prev_exp = ref_alu(op, a, b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_last_valid", out_valid, 1);
      chk("b2b_last_result", result_o, prev_exp);
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk("b2b_idle", busy_o, 0);

      for (int i = 0; i < 70; i++) begin
         int r;
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         r  = int'($urandom_range(0, 7));
         if (r == 0) b = a;
         if (r == 1) a = '0;
         if (r == 2) b[4:0] = 5'd0;
         do_op(op, a, b, int'($urandom_range(0, 3)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
